// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: merges the core's instruction-fetch (i_*) and data (d_*) request ports
// onto a single memory request channel (m_*).
//
// Only one transaction is outstanding at a time. When both sides are valid together, the
// grant goes to the side that did not win last time. Every m_* output comes straight from a
// register; no i_*/d_* input reaches m_* through combinational logic. Each response goes
// back to its owner as a one-cycle addr_ok/data_ok pulse.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   i_valid, i_addr   fetch request, held until i_data_ok
//   i_addr_ok         fetch accepted, pulses together with i_data_ok
//   i_data_ok, i_data fetch response (INSTR_W word selected by address bit 2)
//   d_valid, d_addr   data request, held until d_data_ok
//   d_size, d_strobe  access size code and byte enables (all-zero strobe = read)
//   d_wdata           store data (d_data is the load-data output)
//   d_addr_ok         data accepted, pulses together with d_data_ok
//   d_data_ok, d_data data response (full memory word)
//   m_valid .. m_wdata registered memory request
//   m_ready, m_rdata  memory completion and read data
module core_bus_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // instruction side
  input  logic                  i_valid,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_addr_ok,
  output logic                  i_data_ok,
  output logic [INSTR_W-1:0]    i_data,
  // data side
  input  logic                  d_valid,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [2:0]            d_size,
  input  logic [DATA_W/8-1:0]   d_strobe,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_addr_ok,
  output logic                  d_data_ok,
  output logic [DATA_W-1:0]     d_data,
  // memory side
  output logic                  m_valid,
  output logic                  m_is_write,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [2:0]            m_size,
  output logic [DATA_W/8-1:0]   m_strobe,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_ready,
  input  logic [DATA_W-1:0]     m_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;    // 1: previous grant went to the data side
  logic                  owner_d_q, owner_d_d;  // 1: data side owns the current transaction
  logic                  m_valid_q, m_valid_d;
  logic                  m_is_write_q, m_is_write_d;
  logic [ADDR_W-1:0]     m_addr_q, m_addr_d;
  logic [2:0]            m_size_q, m_size_d;
  logic [DATA_W/8-1:0]   m_strobe_q, m_strobe_d;
  logic [DATA_W-1:0]     m_wdata_q, m_wdata_d;
  logic                  i_ok_q, i_ok_d;
  logic                  d_ok_q, d_ok_d;
  logic [INSTR_W-1:0]    i_data_q, i_data_d;
  logic [DATA_W-1:0]     d_data_q, d_data_d;
  logic                  grant_i, grant_d;

  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    owner_d_d    = owner_d_q;
    m_valid_d    = m_valid_q;
    m_is_write_d = m_is_write_q;
    m_addr_d     = m_addr_q;
    m_size_d     = m_size_q;
    m_strobe_d   = m_strobe_q;
    m_wdata_d    = m_wdata_q;
    i_ok_d       = 1'b0;
    d_ok_d       = 1'b0;
    i_data_d     = i_data_q;
    d_data_d     = d_data_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On a tie the side that lost last time wins.
        grant_d = d_valid & (~i_valid | ~last_d_q);
        grant_i = i_valid & ~grant_d;
        if (grant_d) begin
          m_is_write_d = |d_strobe;
          m_addr_d     = d_addr;
          m_size_d     = d_size;
          m_strobe_d   = d_strobe;
          m_wdata_d    = d_wdata;
        end else if (grant_i) begin
          m_is_write_d = 1'b0;
          m_addr_d     = i_addr;
          m_size_d     = 3'b010;
          m_strobe_d   = '0;
          m_wdata_d    = '0;
        end
        if (grant_d || grant_i) begin
          state_d   = StReq;
          m_valid_d = 1'b1;
          owner_d_d = grant_d;
          last_d_d  = grant_d;
        end
      end
      StReq: begin
        // Committed: completes even if the owner has dropped its valid.
        if (m_ready) begin
          state_d   = StDone;
          m_valid_d = 1'b0;
          if (owner_d_q) begin
            d_ok_d   = 1'b1;
            d_data_d = m_rdata;
          end else begin
            i_ok_d   = 1'b1;
            // Address bit 2 picks the upper or lower instruction word of the bus beat.
            i_data_d = m_addr_q[2] ? m_rdata[2*INSTR_W-1 -: INSTR_W]
                                   : m_rdata[INSTR_W-1:0];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_d_q     <= 1'b0;
      owner_d_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_is_write_q <= 1'b0;
      m_addr_q     <= '0;
      m_size_q     <= '0;
      m_strobe_q   <= '0;
      m_wdata_q    <= '0;
      i_ok_q       <= 1'b0;
      d_ok_q       <= 1'b0;
      i_data_q     <= '0;
      d_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_d_q     <= last_d_d;
      owner_d_q    <= owner_d_d;
      m_valid_q    <= m_valid_d;
      m_is_write_q <= m_is_write_d;
      m_addr_q     <= m_addr_d;
      m_size_q     <= m_size_d;
      m_strobe_q   <= m_strobe_d;
      m_wdata_q    <= m_wdata_d;
      i_ok_q       <= i_ok_d;
      d_ok_q       <= d_ok_d;
      i_data_q     <= i_data_d;
      d_data_q     <= d_data_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_is_write = m_is_write_q;
  assign m_addr     = m_addr_q;
  assign m_size     = m_size_q;
  assign m_strobe   = m_strobe_q;
  assign m_wdata    = m_wdata_q;
  assign i_addr_ok  = i_ok_q;
  assign i_data_ok  = i_ok_q;
  assign i_data     = i_data_q;
  assign d_addr_ok  = d_ok_q;
  assign d_data_ok  = d_ok_q;
  assign d_data     = d_data_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
module tb_core_bus_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_valid;
  logic [AW-1:0]     i_addr;
  logic              i_addr_ok, i_data_ok;
  logic [IW-1:0]     i_data;
  logic              d_valid;
  logic [AW-1:0]     d_addr;
  logic [2:0]        d_size;
  logic [DW/8-1:0]   d_strobe;
  logic [DW-1:0]     d_wdata;
  logic              d_addr_ok, d_data_ok;
  logic [DW-1:0]     d_data;
  logic              m_valid, m_is_write;
  logic [AW-1:0]     m_addr;
  logic [2:0]        m_size;
  logic [DW/8-1:0]   m_strobe;
  logic [DW-1:0]     m_wdata;
  logic              m_ready;
  logic [DW-1:0]     m_rdata;

  always #5 clk = ~clk;

  core_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INSTR_W(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (i_valid),
    .i_addr     (i_addr),
    .i_addr_ok  (i_addr_ok),
    .i_data_ok  (i_data_ok),
    .i_data     (i_data),
    .d_valid    (d_valid),
    .d_addr     (d_addr),
    .d_size     (d_size),
    .d_strobe   (d_strobe),
    .d_wdata    (d_wdata),
    .d_addr_ok  (d_addr_ok),
    .d_data_ok  (d_data_ok),
    .d_data     (d_data),
    .m_valid    (m_valid),
    .m_is_write (m_is_write),
    .m_addr     (m_addr),
    .m_size     (m_size),
    .m_strobe   (m_strobe),
    .m_wdata    (m_wdata),
    .m_ready    (m_ready),
    .m_rdata    (m_rdata)
  );

  typedef struct {
    logic        is_d;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic        mon_en   = 1'b0;

  // Values seen on the memory channel by the last serve() call.
  int          cap_wait;
  logic [63:0] cap_addr, cap_wdata;
  logic        cap_wr;
  logic [2:0]  cap_size;
  logic [7:0]  cap_strobe;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endfunction

  function automatic logic [63:0] iword(input logic [63:0] addr, input logic [63:0] rdata);
    return addr[2] ? {32'd0, rdata[63:32]} : {32'd0, rdata[31:0]};
  endfunction

  // Response monitor: every ok pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("i_addr_ok_tracks_data_ok", 64'(i_addr_ok), 64'(i_data_ok));
      chk("d_addr_ok_tracks_data_ok", 64'(d_addr_ok), 64'(d_data_ok));
      if (i_data_ok || d_data_ok) begin
        chk("ok_exclusive", 64'(i_data_ok & d_data_ok), 64'd0);
        chk("ok_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("ok_owner", 64'(d_data_ok), 64'(e.is_d));
          if (e.is_d) chk("d_data", d_data, e.data);
          else        chk("i_data", 64'(i_data), e.data);
        end
      end
    end
  end

  // Memory model: wait for m_valid, hold m_ready low for lat cycles (fields must stay put),
  // then complete. Returns at the negedge of the DONE cycle.
  task automatic serve(input int lat, input logic [63:0] rdata);
    int waited = 0;
    @(negedge clk);
    while (!m_valid && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    chk("m_valid_seen", 64'(m_valid), 64'd1);
    cap_wait   = waited;
    cap_addr   = m_addr;
    cap_wr     = m_is_write;
    cap_size   = m_size;
    cap_strobe = m_strobe;
    cap_wdata  = m_wdata;
    m_rdata    = rdata;
    for (int c = 0; c < lat; c++) begin
      m_ready = 1'b0;
      @(negedge clk);
      chk("m_valid_held", 64'(m_valid), 64'd1);
      chk("m_addr_stable", m_addr, cap_addr);
      chk("m_is_write_stable", 64'(m_is_write), 64'(cap_wr));
      chk("m_size_stable", 64'(m_size), 64'(cap_size));
      chk("m_strobe_stable", 64'(m_strobe), 64'(cap_strobe));
      chk("m_wdata_stable", m_wdata, cap_wdata);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("m_valid_dropped", 64'(m_valid), 64'd0);
  endtask

  logic [63:0] ia, da, rd;

  initial begin
    reset = 1'b0; i_valid = 1'b0; i_addr = '0; d_valid = 1'b0; d_addr = '0;
    d_size = '0; d_strobe = '0; d_wdata = '0; m_ready = 1'b0; m_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_i_data_ok", 64'(i_data_ok), 64'd0);
    chk("rst_d_data_ok", 64'(d_data_ok), 64'd0);
    chk("rst_i_data", 64'(i_data), 64'd0);
    chk("rst_d_data", d_data, 64'd0);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Single fetch, minimum latency, upper word selected.
    i_valid = 1'b1; i_addr = 64'h8000_0004;
    sb.push_back('{1'b0, 64'h1111_2222});
    serve(0, 64'h1111_2222_3333_4444);
    chk("t1_latency", 64'(cap_wait), 64'd0);
    chk("t1_m_addr", cap_addr, 64'h8000_0004);
    chk("t1_m_size", 64'(cap_size), 64'd2);
    chk("t1_m_is_write", 64'(cap_wr), 64'd0);
    chk("t1_i_data_ok", 64'(i_data_ok), 64'd1);
    i_valid = 1'b0;
    @(negedge clk);
    chk("t1_i_data_ok_once", 64'(i_data_ok), 64'd0);
    chk("t1_i_data_hold", 64'(i_data), 64'h1111_2222);

    // Write with memory stalling five cycles.
    d_valid = 1'b1; d_addr = 64'h8000_0100; d_size = 3'b011; d_strobe = 8'hFF;
    d_wdata = 64'hDEAD_BEEF_0000_0001;
    sb.push_back('{1'b1, 64'h5555_6666_7777_8888});
    serve(5, 64'h5555_6666_7777_8888);
    chk("t2_m_is_write", 64'(cap_wr), 64'd1);
    chk("t2_m_addr", cap_addr, 64'h8000_0100);
    chk("t2_m_strobe", 64'(cap_strobe), 64'hFF);
    chk("t2_m_wdata", cap_wdata, 64'hDEAD_BEEF_0000_0001);
    chk("t2_m_size", 64'(cap_size), 64'd3);
    chk("t2_d_data_ok", 64'(d_data_ok), 64'd1);
    d_valid = 1'b0;
    @(negedge clk);
    chk("t2_d_data_ok_once", 64'(d_data_ok), 64'd0);

    // Flush: data owner drops valid mid-transaction while a fetch waits.
    d_valid = 1'b1; d_addr = 64'h8000_0200; d_strobe = 8'h00;
    sb.push_back('{1'b1, 64'hAAAA_BBBB_CCCC_DDDD});
    sb.push_back('{1'b0, iword(64'h8000_0010, 64'h9999_8888_7777_6666)});
    @(negedge clk);
    chk("t5_granted", 64'(m_valid), 64'd1);
    d_valid = 1'b0; i_valid = 1'b1; i_addr = 64'h8000_0010;
    serve(1, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("t5_d_addr", cap_addr, 64'h8000_0200);
    chk("t5_d_data_ok", 64'(d_data_ok), 64'd1);
    serve(0, 64'h9999_8888_7777_6666);
    chk("t5_i_bubble", 64'(cap_wait), 64'd1);
    chk("t5_i_addr", cap_addr, 64'h8000_0010);
    i_valid = 1'b0;

    // Read through the data port.
    d_valid = 1'b1; d_addr = 64'h8000_0008; d_strobe = 8'h00; d_size = 3'b011;
    sb.push_back('{1'b1, 64'h0123_4567_89AB_CDEF});
    serve(1, 64'h0123_4567_89AB_CDEF);
    chk("t6_m_is_write", 64'(cap_wr), 64'd0);
    chk("t6_m_addr", cap_addr, 64'h8000_0008);
    chk("t6_d_data_ok", 64'(d_data_ok), 64'd1);
    d_valid = 1'b0;
    @(negedge clk);

    // Fresh reset, then both sides continuously valid: D, I, D, I.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ia = 64'h8000_1004; da = 64'h8000_2000;
    i_valid = 1'b1; i_addr = ia; d_valid = 1'b1; d_addr = da; d_strobe = 8'h00;
    for (int k = 0; k < 4; k++) begin
      rd = 64'h1000_0000_2000_0000 + 64'(k) * 64'h0101_0101_0101_0101;
      if (k % 2 == 0) sb.push_back('{1'b1, rd});
      else            sb.push_back('{1'b0, iword(ia, rd)});
      serve(k % 2, rd);
      if (k % 2 == 0) begin
        chk("t3_grant_d", cap_addr, da);
        da = da + 64'd8; d_addr = da;
      end else begin
        chk("t3_grant_i", cap_addr, ia);
        ia = ia + 64'd8; i_addr = ia;
      end
    end
    i_valid = 1'b0; d_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of a stalled transaction.
    d_valid = 1'b1; d_addr = 64'h8000_0300; d_strobe = 8'h0F;
    @(negedge clk);
    chk("t4_in_req", 64'(m_valid), 64'd1);
    reset = 1'b0; d_valid = 1'b0;
    @(negedge clk);
    chk("t4_m_valid", 64'(m_valid), 64'd0);
    chk("t4_i_ok", 64'(i_data_ok), 64'd0);
    chk("t4_d_ok", 64'(d_data_ok), 64'd0);
    chk("t4_m_addr", m_addr, 64'd0);
    chk("t4_d_data", d_data, 64'd0);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_idle_after", 64'(m_valid), 64'd0);
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
